// File: rtl/huffman_dec_if.sv
// huffman_dec_if: bus bundle for the Huffman decoder.
//   code_valid, HC1..HC6, M1..M6 : code-table load strobe and table contents
//   bit_valid, bit_in, bit_ready : serial MSB-first bitstream input handshake
//   sym_valid, sym_data          : decoded symbol index (1..6), one-cycle pulse
//   dec_err                      : sticky decode error flag
// master drives the table/bitstream side; slave is the decoder.
interface huffman_dec_if;
  logic       code_valid;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0] M1, M2, M3, M4, M5, M6;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       sym_valid;
  logic [7:0] sym_data;
  logic       dec_err;

  modport master (
    output code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
           M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
    input  bit_ready, sym_valid, sym_data, dec_err
  );

  modport slave (
    input  code_valid, HC1, HC2, HC3, HC4, HC5, HC6,
           M1, M2, M3, M4, M5, M6, bit_valid, bit_in,
    output bit_ready, sym_valid, sym_data, dec_err
  );
endinterface

// File: rtl/huffman_dec.sv
// huffman_dec: serial Huffman decoder, counterpart of the grayscale encoder.
// Captures a six-entry code table (HCn masked by Mn, Mn = 2^L-1, 0 = unused)
// on code_valid, then shifts in an MSB-first bitstream and emits the index
// of each completed codeword one clock after its last bit.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : huffman_dec_if.slave (table load, bit input, symbol output, error)
//   DCNT1..DCNT6 : per-symbol decode counters (only with HUFF_DEC_CNT_EN)
// Parameter MAX_LEN: longest legal codeword; an unmatched partial word of
// this length sends the decoder to its error state.
// Optional macro HUFF_DEC_CNT_EN adds the saturating DCNTn counters.
module huffman_dec #(
  parameter int MAX_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  huffman_dec_if.slave bus
`ifdef HUFF_DEC_CNT_EN
  ,
  output logic [7:0] DCNT1,
  output logic [7:0] DCNT2,
  output logic [7:0] DCNT3,
  output logic [7:0] DCNT4,
  output logic [7:0] DCNT5,
  output logic [7:0] DCNT6
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0] state;

  // Stored table: masked codeword, mask and codeword length per entry.
  logic [7:0] hc_q [6];
  logic [7:0] m_q  [6];
  logic [3:0] l_q  [6];

  logic [7:0] hc_in [6];
  logic [7:0] m_in  [6];
  logic [3:0] l_in  [6];

  // Only seven bits are ever held between bits; the eighth arrives with
  // the final accept and is consumed combinationally.
  logic [6:0] sr;
  logic [3:0] len;
  logic [7:0] sr_n;
  logic [3:0] len_n;

  logic       hit;
  logic [2:0] hit_idx;
  logic       accept;

  logic       sym_valid_q;
  logic [7:0] sym_data_q;
  logic       dec_err_q;

  always_comb begin
    hc_in[0] = bus.HC1; hc_in[1] = bus.HC2; hc_in[2] = bus.HC3;
    hc_in[3] = bus.HC4; hc_in[4] = bus.HC5; hc_in[5] = bus.HC6;
    m_in[0]  = bus.M1;  m_in[1]  = bus.M2;  m_in[2]  = bus.M3;
    m_in[3]  = bus.M4;  m_in[4]  = bus.M5;  m_in[5]  = bus.M6;
    // Length = position of highest mask bit + 1 (0 for an unused entry).
    for (int unsigned i = 0; i < 6; i++) begin
      l_in[i] = '0;
      for (int unsigned b = 0; b < 8; b++) begin
        if (m_in[i][b]) l_in[i] = 4'(b + 1);
      end
    end
  end

  assign accept = (state == ST_RUN) && bus.bit_valid;

  // Lowest-numbered matching entry wins if the table is not prefix-free.
  always_comb begin
    sr_n    = {sr, bus.bit_in};
    len_n   = len + 4'd1;
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (!hit && (m_q[i] != '0) && (l_q[i] == len_n) &&
          ((sr_n & m_q[i]) == hc_q[i])) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      for (int unsigned i = 0; i < 6; i++) begin
        hc_q[i] <= '0;
        m_q[i]  <= '0;
        l_q[i]  <= '0;
      end
      sr          <= '0;
      len         <= '0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= '0;
      dec_err_q   <= 1'b0;
    end else begin
      sym_valid_q <= 1'b0;
      if (bus.code_valid) begin
        // A load takes priority over a same-cycle bit, which is dropped.
        for (int unsigned i = 0; i < 6; i++) begin
          hc_q[i] <= hc_in[i] & m_in[i];
          m_q[i]  <= m_in[i];
          l_q[i]  <= l_in[i];
        end
        sr        <= '0;
        len       <= '0;
        state     <= ST_RUN;
        dec_err_q <= 1'b0;
      end else if (accept) begin
        if (hit) begin
          sym_valid_q <= 1'b1;
          sym_data_q  <= {5'd0, hit_idx} + 8'd1;
          sr          <= '0;
          len         <= '0;
        end else if (len_n == 4'(MAX_LEN)) begin
          state     <= ST_ERR;
          dec_err_q <= 1'b1;
          sr        <= '0;
          len       <= '0;
        end else begin
          sr  <= sr_n[6:0];
          len <= len_n;
        end
      end
    end
  end

  assign bus.bit_ready = (state == ST_RUN);
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_data  = sym_data_q;
  assign bus.dec_err   = dec_err_q;

`ifdef HUFF_DEC_CNT_EN
  logic [7:0] dcnt [6];

  // Counted at the edge that raises sym_valid, so DCNTn is current while
  // the pulse is visible.
  always_ff @(posedge clk) begin
    if (reset || bus.code_valid) begin
      for (int unsigned i = 0; i < 6; i++) dcnt[i] <= '0;
    end else if (accept && hit && (dcnt[hit_idx] != 8'hFF)) begin
      dcnt[hit_idx] <= dcnt[hit_idx] + 8'd1;
    end
  end

  assign DCNT1 = dcnt[0];
  assign DCNT2 = dcnt[1];
  assign DCNT3 = dcnt[2];
  assign DCNT4 = dcnt[3];
  assign DCNT5 = dcnt[4];
  assign DCNT6 = dcnt[5];
`endif

endmodule

// File: tb/tb_huffman_dec.sv
// tb_huffman_dec: directed, table-driven bench for huffman_dec.
// Each vector row drives one clock of inputs and lists the outputs expected
// just after that edge; reset behaviour is exercised by hand-written steps.
module tb_huffman_dec;

  logic clk;
  logic reset;
  huffman_dec_if bus_if ();

`ifdef HUFF_DEC_CNT_EN
  logic [7:0] dcnt1, dcnt2, dcnt3, dcnt4, dcnt5, dcnt6;
`endif

  huffman_dec #(.MAX_LEN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
`ifdef HUFF_DEC_CNT_EN
    ,
    .DCNT1 (dcnt1),
    .DCNT2 (dcnt2),
    .DCNT3 (dcnt3),
    .DCNT4 (dcnt4),
    .DCNT5 (dcnt5),
    .DCNT6 (dcnt6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         cv;
    bit         tsel;   // 0: full table, 1: entries 5 and 6 unused
    bit         bv;
    bit         b;
    bit         e_sv;
    logic [7:0] e_dat;
    bit         e_err;
    bit         e_rdy;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] last_d;
  int         cnt_idx;
  int         errors;
  int         checks;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic set_table(input bit tsel);
    bus_if.HC1 = 8'h00; bus_if.M1 = 8'h01;
    bus_if.HC2 = 8'h02; bus_if.M2 = 8'h03;
    bus_if.HC3 = 8'h06; bus_if.M3 = 8'h07;
    bus_if.HC4 = 8'h0E; bus_if.M4 = 8'h0F;
    bus_if.HC5 = 8'h1E; bus_if.M5 = tsel ? 8'h00 : 8'h1F;
    bus_if.HC6 = 8'h1F; bus_if.M6 = tsel ? 8'h00 : 8'h1F;
  endtask

  task automatic add(input bit cv, input bit tsel, input bit bv, input bit b,
                     input bit esv, input logic [7:0] ed, input bit eerr, input bit erdy);
    vec_t v;
    if (esv) last_d = ed;
    v.cv = cv; v.tsel = tsel; v.bv = bv; v.b = b;
    v.e_sv = esv; v.e_dat = last_d; v.e_err = eerr; v.e_rdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic add_bit(input bit b, input bit esv, input logic [7:0] ed);
    add(1'b0, 1'b0, 1'b1, b, esv, ed, 1'b0, 1'b1);
  endtask

  task automatic add_cv(input bit tsel);
    add(1'b1, tsel, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic build();
    int nb;
    bit bb;
    last_d = 8'h00;
    // Bits before any table: all ignored.
    for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 1'b1, 1'(i & 1), 1'b0, 8'h00, 1'b0, 1'b0);
    // Codewords 0,10,110,1110,11110,11111 back-to-back.
    add_cv(1'b0);
    for (int k = 1; k <= 6; k++) begin
      nb = (k == 6) ? 5 : k;
      for (int j = 0; j < nb; j++) begin
        bb = (k == 6) ? 1'b1 : (j != nb - 1);
        add_bit(bb, j == nb - 1, 8'(k));
      end
    end
    // Reload, then 16 one-bit codewords on consecutive cycles.
    add_cv(1'b0);
    for (int i = 0; i < 16; i++) add_bit(1'b0, 1'b1, 8'd1);
    cnt_idx = vecs.size() - 1;
    // Eight unmatched ones with entries 5/6 unused -> error, then recovery.
    add_cv(1'b1);
    for (int i = 0; i < 7; i++) add_bit(1'b1, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    add_cv(1'b0);
    // Partial 11, load with a colliding bit, then a lone 0.
    add_bit(1'b1, 1'b0, 8'h00);
    add_bit(1'b1, 1'b0, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    add_bit(1'b0, 1'b1, 8'd1);
    // Idle cycles: sym_data holds.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus_if.code_valid = 1'b0;
    bus_if.bit_valid  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input bit esv, input bit eerr, input bit erdy);
    chk({tag, ".sym_valid"}, {7'd0, bus_if.sym_valid}, {7'd0, esv});
    chk({tag, ".dec_err"},   {7'd0, bus_if.dec_err},   {7'd0, eerr});
    chk({tag, ".bit_ready"}, {7'd0, bus_if.bit_ready}, {7'd0, erdy});
  endtask

  initial begin
    vec_t v;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus_if.code_valid = 1'b0;
    bus_if.bit_valid  = 1'b0;
    bus_if.bit_in     = 1'b0;
    set_table(1'b0);
    build();

    step();
    step();
    reset = 1'b0;
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.sym_data", bus_if.sym_data, 8'h00);
`ifdef HUFF_DEC_CNT_EN
    chk("reset.dcnt1", dcnt1, 8'h00);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.cv) set_table(v.tsel);
      bus_if.code_valid = v.cv;
      bus_if.bit_valid  = v.bv;
      bus_if.bit_in     = v.b;
      step();
      chk_out($sformatf("v%0d", i), v.e_sv, v.e_err, v.e_rdy);
      chk($sformatf("v%0d.sym_data", i), bus_if.sym_data, v.e_dat);
`ifdef HUFF_DEC_CNT_EN
      if (i == cnt_idx) chk("dcnt1_after_16", dcnt1, 8'd16);
`endif
    end

    // Reset in the middle of a partial codeword.
    set_table(1'b0);
    bus_if.code_valid = 1'b1;
    step();
    bus_if.bit_valid = 1'b1; bus_if.bit_in = 1'b1;
    step();
    chk_out("mid.partial", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    bus_if.bit_valid = 1'b1; bus_if.bit_in = 1'b0;
    step();
    reset = 1'b0;
    chk_out("mid.reset", 1'b0, 1'b0, 1'b0);
    chk("mid.reset.sym_data", bus_if.sym_data, 8'h00);
    for (int i = 0; i < 3; i++) begin
      bus_if.bit_valid = 1'b1; bus_if.bit_in = 1'b0;
      step();
      chk_out($sformatf("mid.ignored%0d", i), 1'b0, 1'b0, 1'b0);
    end
    set_table(1'b0);
    bus_if.code_valid = 1'b1;
    step();
    chk_out("mid.reload", 1'b0, 1'b0, 1'b1);
    bus_if.bit_valid = 1'b1; bus_if.bit_in = 1'b0;
    step();
    chk_out("mid.decode", 1'b1, 1'b0, 1'b1);
    chk("mid.decode.sym_data", bus_if.sym_data, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
